// File: rtl/cube_pkg.sv
// Shared constants, state encodings and frame helpers for the 3x3x3 LED cube scanner.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cube_pkg;

  localparam int NUM_PLANES     = 3;
  localparam int ROWS_PER_PLANE = 9;
  localparam int FRAME_W        = NUM_PLANES * ROWS_PER_PLANE;

  // Scan FSM encodings, kept as plain constants so legacy code can compare against them.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  // Row line positions inside one plane's 9-bit slice of the frame.
  localparam int R1_BOT = 0;
  localparam int R2_BOT = 1;
  localparam int R3_BOT = 2;
  localparam int R1_MID = 3;
  localparam int R2_MID = 4;
  localparam int R3_MID = 5;
  localparam int R1_TOP = 6;
  localparam int R2_TOP = 7;
  localparam int R3_TOP = 8;

  typedef logic [FRAME_W-1:0]        frame_t;
  typedef logic [ROWS_PER_PLANE-1:0] rows_t;

  // Extract the row lines of one plane; plane 3 is not a real plane and yields all-off.
  function automatic rows_t plane_rows(frame_t f, logic [1:0] plane);
    rows_t r;
    case (plane)
      2'd0:    r = f[0*ROWS_PER_PLANE +: ROWS_PER_PLANE];
      2'd1:    r = f[1*ROWS_PER_PLANE +: ROWS_PER_PLANE];
      2'd2:    r = f[2*ROWS_PER_PLANE +: ROWS_PER_PLANE];
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cube_frame_buffer.sv
// Double-buffered frame store: one pending slot fed by valid/ready, one active image for the scanner.
// Latency: accepted frame becomes active on the first swap pulse after the accept cycle.
// Backpressure: frame_ready_o is low while the pending slot holds a frame not yet swapped in.
module cube_frame_buffer
  import cube_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  frame_t frame_data_i,
  input  logic   frame_valid_i,
  output logic   frame_ready_o,
  input  logic   swap_i,
  output frame_t active_o
);

  frame_t pending_q, pending_d;
  frame_t active_q, active_d;
  logic   pending_full_q, pending_full_d;

  // A swap only moves data when something is pending; an accept only happens when empty,
  // so the two can never collide on the same pending slot.
  always_comb begin
    pending_d      = pending_q;
    active_d       = active_q;
    pending_full_d = pending_full_q;
    if (swap_i && pending_full_q) begin
      active_d       = pending_q;
      pending_full_d = 1'b0;
    end else if (frame_valid_i && !pending_full_q) begin
      pending_d      = frame_data_i;
      pending_full_d = 1'b1;
    end
  end

  // Buffer state registers; reset discards any pending frame and blanks the active image.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q      <= '0;
      active_q       <= '0;
      pending_full_q <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      active_q       <= active_d;
      pending_full_q <= pending_full_d;
    end
  end

  assign frame_ready_o = ~pending_full_q;
  assign active_o      = active_q;

endmodule

// File: rtl/cube_scan_controller.sv
// Time-multiplexed plane scanner for the 3x3x3 LED cube with blanking between plane slots.
// Latency: outputs are registered; enable/lamp_test changes show on the outputs one cycle later.
// Backpressure: new frames stall on frame_ready_o until the next plane-0 swap point frees the buffer.
module cube_scan_controller
  import cube_pkg::*;
#(
  parameter int ON_CYCLES    = 16000,
  parameter int BLANK_CYCLES = 600
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic                      lamp_test_i,
  input  logic [FRAME_W-1:0]        frame_data_i,
  input  logic                      frame_valid_i,
  output logic                      frame_ready_o,
  output logic [NUM_PLANES-1:0]     plane_sel_n_o,
  output logic [ROWS_PER_PLANE-1:0] row_drive_o,
  output logic [1:0]                cur_plane_o,
  output logic                      frame_done_o
);

  localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [1:0]       LAST_PLANE = 2'(NUM_PLANES - 1);

  logic [1:0]                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [1:0]                plane_q, plane_d;
  logic [NUM_PLANES-1:0]     plane_sel_n_q, plane_sel_n_d;
  logic [ROWS_PER_PLANE-1:0] row_drive_q, row_drive_d;
  logic                      frame_done_q, frame_done_d;
  logic                      swap;
  frame_t                    active_frame;

  cube_frame_buffer u_frame_buffer (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .frame_data_i  (frame_data_i),
    .frame_valid_i (frame_valid_i),
    .frame_ready_o (frame_ready_o),
    .swap_i        (swap),
    .active_o      (active_frame)
  );

  // Sequencing: every entry into plane-0 blanking is a swap point, whether from idle or after plane 2.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    plane_d      = plane_q;
    swap         = 1'b0;
    frame_done_d = 1'b0;
    if (!enable_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      plane_d = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          plane_d = 2'd0;
          swap    = 1'b1;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == ON_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (plane_q == LAST_PLANE) begin
              plane_d      = 2'd0;
              swap         = 1'b1;
              frame_done_d = 1'b1;
            end else begin
              plane_d = plane_q + 2'd1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          plane_d = 2'd0;
        end
      endcase
    end
  end

  // Output decode from the next state, so the pin registers line up with the FSM state.
  // The active frame is always settled by the first DRIVE cycle because BLANK lasts at least one cycle.
  always_comb begin
    plane_sel_n_d = '1;
    row_drive_d   = '0;
    if (state_d == ST_DRIVE) begin
      plane_sel_n_d = ~(NUM_PLANES'(1) << plane_d);
      row_drive_d   = lamp_test_i ? '1 : plane_rows(active_frame, plane_d);
    end
  end

  // FSM, slot counter and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      plane_q       <= 2'd0;
      plane_sel_n_q <= '1;
      row_drive_q   <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      plane_q       <= plane_d;
      plane_sel_n_q <= plane_sel_n_d;
      row_drive_q   <= row_drive_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign plane_sel_n_o = plane_sel_n_q;
  assign row_drive_o   = row_drive_q;
  assign cur_plane_o   = plane_q;
  assign frame_done_o  = frame_done_q;

endmodule

// File: tb/tb_cube_scan_controller.sv
// Directed bench for cube_scan_controller with short slots (ON=4, BLANK=2, period 18).
// Latency: checks sample outputs 1 time unit after each rising edge.
// Backpressure: exercises the pending-buffer stall on frame_ready.
module tb_cube_scan_controller;
  import cube_pkg::*;

  localparam int ON     = 4;
  localparam int BLANK  = 2;
  localparam int SLOT   = ON + BLANK;
  localparam int PERIOD = 3 * SLOT;

  // Plane slices listed plane2, plane1, plane0.
  localparam logic [26:0] FRAME_A = {9'h100, 9'h010, 9'h101};
  localparam logic [26:0] FRAME_B = {9'h0AA, 9'h155, 9'h0F0};
  localparam logic [26:0] FRAME_C = {9'h007, 9'h038, 9'h1C0};
  localparam logic [26:0] FRAME_D = {9'h1FE, 9'h0C3, 9'h03C};

  logic        clk;
  logic        rst;
  logic        enable;
  logic        lamp_test;
  logic [26:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic [2:0]  plane_sel_n;
  logic [8:0]  row_drive;
  logic [1:0]  cur_plane;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  cube_scan_controller #(
    .ON_CYCLES    (ON),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (enable),
    .lamp_test_i   (lamp_test),
    .frame_data_i  (frame_data),
    .frame_valid_i (frame_valid),
    .frame_ready_o (frame_ready),
    .plane_sel_n_o (plane_sel_n),
    .row_drive_o   (row_drive),
    .cur_plane_o   (cur_plane),
    .frame_done_o  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected values at position p (0..17) of a frame that starts on plane-0 blanking.
  function automatic logic [2:0] exp_sel(int p);
    int slot = p / SLOT;
    int pos  = p % SLOT;
    logic [2:0] one = 3'b001;
    if (pos < BLANK) return 3'b111;
    return ~(one << slot);
  endfunction

  function automatic logic [8:0] exp_row(logic [26:0] f, int p, bit lamp);
    int slot = p / SLOT;
    int pos  = p % SLOT;
    if (pos < BLANK) return 9'h000;
    if (lamp) return 9'h1FF;
    return f[slot*9 +: 9];
  endfunction

  function automatic logic [1:0] exp_plane(int p);
    return 2'(p / SLOT);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] want;
    rst = 1'b1; enable = 1'b0; lamp_test = 1'b0; frame_valid = 1'b0; frame_data = '0;
    step(); step();
    want = {3'b111, 9'h000, 2'd0, 1'b0, 1'b1};
    checks++;
    if ({plane_sel_n, row_drive, cur_plane, frame_done, frame_ready} !== want) begin
      failures++;
      $display("FAIL reset_vals got=%h want=%h", {plane_sel_n, row_drive, cur_plane, frame_done, frame_ready}, want);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({plane_sel_n, row_drive, cur_plane, frame_done, frame_ready} !== want) begin
        failures++;
        $display("FAIL idle_hold cyc=%0d got=%h want=%h", i, {plane_sel_n, row_drive, cur_plane, frame_done, frame_ready}, want);
      end
    end
  endtask

  task automatic test_load_and_scan();
    logic [14:0] want;
    frame_data = FRAME_A; frame_valid = 1'b1;
    step();
    checks++;
    if (frame_ready !== 1'b0) begin
      failures++; $display("FAIL accept_ready_low got=%b want=0", frame_ready);
    end
    frame_valid = 1'b0; enable = 1'b1;
    step();
    checks++;
    if (frame_ready !== 1'b1) begin
      failures++; $display("FAIL swap_ready_high got=%b want=1", frame_ready);
    end
    for (int k = 0; k < PERIOD; k++) begin
      if (k > 0) step();
      want = {exp_sel(k), exp_row(FRAME_A, k, 1'b0), exp_plane(k), 1'b0};
      checks++;
      if ({plane_sel_n, row_drive, cur_plane, frame_done} !== want) begin
        failures++;
        $display("FAIL scan_a k=%0d got=%h want=%h", k, {plane_sel_n, row_drive, cur_plane, frame_done}, want);
      end
    end
    step();
    want = {3'b111, 9'h000, 2'd0, 1'b1};
    checks++;
    if ({plane_sel_n, row_drive, cur_plane, frame_done} !== want) begin
      failures++;
      $display("FAIL frame_done_pulse got=%h want=%h", {plane_sel_n, row_drive, cur_plane, frame_done}, want);
    end
  endtask

  // Starts at frame position 0 with FRAME_A active and the buffer empty.
  task automatic test_pending_stall();
    logic [14:0] want;
    logic [26:0] f;
    int p;
    for (int k = 1; k <= 3; k++) begin
      step();
      want = {exp_sel(k), exp_row(FRAME_A, k, 1'b0), exp_plane(k), 1'b0};
      checks++;
      if ({plane_sel_n, row_drive, cur_plane, frame_done} !== want) begin
        failures++;
        $display("FAIL pre_offer k=%0d got=%h want=%h", k, {plane_sel_n, row_drive, cur_plane, frame_done}, want);
      end
    end
    frame_data = FRAME_B; frame_valid = 1'b1;
    for (int k = 4; k <= 23; k++) begin
      step();
      p = k % PERIOD;
      f = (k < PERIOD) ? FRAME_A : FRAME_B;
      want = {exp_sel(p), exp_row(f, p, 1'b0), exp_plane(p), (k == PERIOD)};
      checks++;
      if ({plane_sel_n, row_drive, cur_plane, frame_done} !== want) begin
        failures++;
        $display("FAIL stall_scan k=%0d got=%h want=%h", k, {plane_sel_n, row_drive, cur_plane, frame_done}, want);
      end
      checks++;
      if (frame_ready !== (k == PERIOD)) begin
        failures++;
        $display("FAIL stall_ready k=%0d got=%b want=%b", k, frame_ready, (k == PERIOD));
      end
      if (k == 4) frame_data = FRAME_C;
      if (k == 19) frame_valid = 1'b0;
    end
  endtask

  // Starts at frame position 5 with FRAME_B active and FRAME_C pending.
  task automatic test_lamp();
    logic [14:0] want;
    bit lamp_eff;
    for (int k = 6; k <= 14; k++) begin
      step();
      lamp_eff = (k >= 9) && (k <= 13);
      want = {exp_sel(k), exp_row(FRAME_B, k, lamp_eff), exp_plane(k), 1'b0};
      checks++;
      if ({plane_sel_n, row_drive, cur_plane, frame_done} !== want) begin
        failures++;
        $display("FAIL lamp_scan k=%0d got=%h want=%h", k, {plane_sel_n, row_drive, cur_plane, frame_done}, want);
      end
      if (k == 8) lamp_test = 1'b1;
      if (k == 13) lamp_test = 1'b0;
    end
  endtask

  // Starts at frame position 14 (plane 2 drive) with FRAME_C still pending.
  task automatic test_enable_drop();
    logic [14:0] want;
    logic [15:0] want_idle;
    step();
    want = {exp_sel(15), exp_row(FRAME_B, 15, 1'b0), exp_plane(15), 1'b0};
    checks++;
    if ({plane_sel_n, row_drive, cur_plane, frame_done} !== want) begin
      failures++;
      $display("FAIL pre_drop got=%h want=%h", {plane_sel_n, row_drive, cur_plane, frame_done}, want);
    end
    enable = 1'b0;
    want_idle = {3'b111, 9'h000, 2'd0, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({plane_sel_n, row_drive, cur_plane, frame_done, frame_ready} !== want_idle) begin
        failures++;
        $display("FAIL drop_idle cyc=%0d got=%h want=%h", i, {plane_sel_n, row_drive, cur_plane, frame_done, frame_ready}, want_idle);
      end
    end
    enable = 1'b1;
    step();
    checks++;
    if (frame_ready !== 1'b1) begin
      failures++; $display("FAIL reenable_swap got=%b want=1", frame_ready);
    end
    for (int k = 0; k < PERIOD; k++) begin
      if (k > 0) step();
      want = {exp_sel(k), exp_row(FRAME_C, k, 1'b0), exp_plane(k), 1'b0};
      checks++;
      if ({plane_sel_n, row_drive, cur_plane, frame_done} !== want) begin
        failures++;
        $display("FAIL reenable_scan k=%0d got=%h want=%h", k, {plane_sel_n, row_drive, cur_plane, frame_done}, want);
      end
    end
    step();
    checks++;
    if (frame_done !== 1'b1) begin
      failures++; $display("FAIL reenable_done got=%b want=1", frame_done);
    end
  endtask

  // Starts at frame position 0 with FRAME_C active and the buffer empty.
  task automatic test_reset_mid();
    logic [14:0] want;
    logic [15:0] want_rst;
    frame_data = FRAME_D; frame_valid = 1'b1;
    step();
    checks++;
    if (frame_ready !== 1'b0) begin
      failures++; $display("FAIL mid_accept got=%b want=0", frame_ready);
    end
    frame_valid = 1'b0;
    step(); step();
    want = {exp_sel(3), exp_row(FRAME_C, 3, 1'b0), exp_plane(3), 1'b0};
    checks++;
    if ({plane_sel_n, row_drive, cur_plane, frame_done} !== want) begin
      failures++;
      $display("FAIL pre_rst got=%h want=%h", {plane_sel_n, row_drive, cur_plane, frame_done}, want);
    end
    rst = 1'b1;
    step();
    want_rst = {3'b111, 9'h000, 2'd0, 1'b0, 1'b1};
    checks++;
    if ({plane_sel_n, row_drive, cur_plane, frame_done, frame_ready} !== want_rst) begin
      failures++;
      $display("FAIL mid_rst got=%h want=%h", {plane_sel_n, row_drive, cur_plane, frame_done, frame_ready}, want_rst);
    end
    rst = 1'b0;
    step();
    for (int k = 0; k < PERIOD; k++) begin
      if (k > 0) step();
      want = {exp_sel(k), 9'h000, exp_plane(k), 1'b0};
      checks++;
      if ({plane_sel_n, row_drive, cur_plane, frame_done} !== want) begin
        failures++;
        $display("FAIL post_rst_scan k=%0d got=%h want=%h", k, {plane_sel_n, row_drive, cur_plane, frame_done}, want);
      end
    end
    checks++;
    if (frame_ready !== 1'b1) begin
      failures++; $display("FAIL post_rst_ready got=%b want=1", frame_ready);
    end
  endtask

  initial begin
    test_reset();
    test_load_and_scan();
    test_pending_stall();
    test_lamp();
    test_enable_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Time limit: the directed sequence needs only a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "time limit");
  end

endmodule
